axi_lite_master_biu: RTL

AXI_LITE_MASTER_BIU -- requirements
Module: axi_lite_master_biu

---
 rtl/axi_lite_master_biu.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master_biu.sv
// ---------------------------------------------------------------------------
// axi_lite_master_biu
//
// Bus interface unit that turns a simple core request/response handshake into
// single AXI4-Lite transactions, with at most one transaction in flight.
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   req_valid_i / req_ready_o  core request handshake (ready only when idle)
//   req_we_i                   1 = write, 0 = read
//   req_addr_i                 byte address
//   req_wdata_i, req_wstrb_i   write data and byte strobes
//   rsp_valid_o / rsp_ready_i  core response handshake
//   rsp_rdata_o, rsp_err_o     read data (0 for writes); error flag
//   aw*, w*, b*                AXI-Lite write address / data / response
//   ar*, r*                    AXI-Lite read address / data
//
// Every AXI valid/ready output, req_ready_o and rsp_valid_o is decoded from
// registered state only, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module axi_lite_master_biu #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter logic [2:0]  PROT   = 3'b000,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wstrb_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,

    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,

    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,

    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,

    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,

    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RSP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              aw_hs;
    logic              w_hs;
    logic              aw_all;
    logic              w_all;

    // Only bit 1 of a response distinguishes success from error.
    logic              unused_resp_lsb;
    assign unused_resp_lsb = rresp[0] ^ bresp[0];

    // ------------------------------------------------------------------
    // Output decode: registered state only
    // ------------------------------------------------------------------
    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign arvalid     = (state_q == RD_ADDR);
    assign araddr      = addr_q;
    assign arprot      = PROT;
    assign rready      = (state_q == RD_DATA);

    // Each write channel drops its valid on its own handshake; the sticky
    // done flags keep it low while the other channel is still pending.
    assign awvalid     = (state_q == WR_REQ) && !aw_done_q;
    assign awaddr      = addr_q;
    assign awprot      = PROT;
    assign wvalid      = (state_q == WR_REQ) && !w_done_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign bready      = (state_q == WR_RESP);

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign aw_all = aw_done_q || aw_hs;
    assign w_all  = w_done_q || w_hs;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    // Direction is carried by the state from here on.
                    addr_d    = req_addr_i;
                    wdata_d   = req_wdata_i;
                    wstrb_d   = req_wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we_i ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = rresp[1];
                    state_d = RSP;
                end
            end
            WR_REQ: begin
                if (aw_all && w_all) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end else begin
                    aw_done_d = aw_all;
                    w_done_d  = w_all;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    rdata_d = '0;
                    err_d   = bresp[1];
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

endmodule
